// File: rtl/as_slave_bpi.sv
// Wishbone slave with a four-entry register map (ID, CTRL, DATA, STATUS).
// A configurable number of wait states is inserted before each single-cycle ack.
module as_slave_bpi #(
  parameter logic [63:0] slave_id    = 64'hC0FFEE00C0FFEE00,
  parameter int unsigned addr_width  = 64,
  parameter int unsigned data_width  = 64,
  parameter int unsigned wait_cycles = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [addr_width-1:0]   wb_s_addr_i,
  input  logic [data_width-1:0]   wb_s_dat_i,
  output logic [data_width-1:0]   wb_s_dat_o,
  input  logic                    wb_s_we_i,
  input  logic [data_width/8-1:0] wb_s_sel_i,
  input  logic                    wb_s_stb_i,
  input  logic                    wb_s_cyc_i,
  output logic                    wb_s_ack_o,
  output logic [data_width-1:0]   ctrl_o,
  output logic [data_width-1:0]   data_o,
  input  logic [data_width-1:0]   status_i
);

  localparam int unsigned sel_width = data_width / 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t                  state;
  logic [3:0]              wait_cnt;
  logic [1:0]              idx_q;
  logic                    we_q;
  logic [sel_width-1:0]    sel_q;
  logic [data_width-1:0]   wdat_q;
  logic [data_width-1:0]   id_q;
  logic [data_width-1:0]   ctrl_q;
  logic [data_width-1:0]   data_q;
  logic [data_width-1:0]   rdat_q;
  logic                    ack_q;

  logic                    req_c;
  logic                    enter_ack_c;
  logic [1:0]              c_idx;
  logic                    c_we;
  logic [sel_width-1:0]    c_sel;
  logic [data_width-1:0]   c_wdat;
  logic [data_width-1:0]   c_old;
  logic [data_width-1:0]   c_merged;
  logic [data_width-1:0]   c_rdat;
  logic                    unused_addr;

  assign unused_addr = ^wb_s_addr_i;

  assign req_c       = wb_s_cyc_i && wb_s_stb_i;
  assign enter_ack_c = ((state == S_IDLE) && req_c && (wait_cycles == 0)) ||
                       ((state == S_WAIT) && wb_s_cyc_i && (wait_cnt == 4'd0));

  // Commit operands: straight from the bus on a zero-wait transfer, else from the capture.
  always_comb begin
    c_idx  = idx_q;
    c_we   = we_q;
    c_sel  = sel_q;
    c_wdat = wdat_q;
    if (state == S_IDLE) begin
      c_idx  = wb_s_addr_i[4:3];
      c_we   = wb_s_we_i;
      c_sel  = wb_s_sel_i;
      c_wdat = wb_s_dat_i;
    end
    c_old    = (c_idx == 2'd1) ? ctrl_q : data_q;
    c_merged = c_old;
    for (int unsigned k = 0; k < sel_width; k++) begin
      if (c_sel[k]) c_merged[8*k +: 8] = c_wdat[8*k +: 8];
    end
    case (c_idx)
      2'd0:    c_rdat = id_q;
      2'd1:    c_rdat = ctrl_q;
      2'd2:    c_rdat = data_q;
      default: c_rdat = status_i;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      wait_cnt <= 4'd0;
      ack_q    <= 1'b0;
      rdat_q   <= '0;
      id_q     <= data_width'(slave_id);
      ctrl_q   <= '0;
      data_q   <= '0;
      idx_q    <= 2'd0;
      we_q     <= 1'b0;
      sel_q    <= '0;
      wdat_q   <= '0;
    end else begin
      ack_q <= enter_ack_c;
      case (state)
        S_IDLE: begin
          if (req_c) begin
            idx_q  <= wb_s_addr_i[4:3];
            we_q   <= wb_s_we_i;
            sel_q  <= wb_s_sel_i;
            wdat_q <= wb_s_dat_i;
            if (wait_cycles == 0) begin
              state <= S_ACK;
            end else begin
              state    <= S_WAIT;
              wait_cnt <= 4'(wait_cycles - 1);
            end
          end
        end
        S_WAIT: begin
          // Dropping cyc aborts; stb is not looked at once the request is captured.
          if (!wb_s_cyc_i) begin
            state <= S_IDLE;
          end else if (wait_cnt == 4'd0) begin
            state <= S_ACK;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_ACK:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      if (enter_ack_c) begin
        if (c_we) begin
          if (c_idx == 2'd1) ctrl_q <= c_merged;
          if (c_idx == 2'd2) data_q <= c_merged;
        end else begin
          rdat_q <= c_rdat;
        end
      end
    end
  end

  assign wb_s_ack_o = ack_q;
  assign wb_s_dat_o = rdat_q;
  assign ctrl_o     = ctrl_q;
  assign data_o     = data_q;

endmodule

// File: tb/tb_as_slave_bpi.sv
// Bench for as_slave_bpi: two instances (1 and 3 wait states) checked every cycle
// against a transaction-level register model, plus literal spot checks.
module tb_as_slave_bpi;

  localparam logic [63:0] ID_VAL = 64'hC0FFEE00C0FFEE00;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst    [2];
  logic [63:0] addr   [2];
  logic [63:0] wdat   [2];
  logic [63:0] status [2];
  logic        we     [2];
  logic        stb    [2];
  logic        cyc    [2];
  logic [7:0]  sel    [2];
  logic [63:0] rdat   [2];
  logic [63:0] ctrl   [2];
  logic [63:0] data   [2];
  logic        ack    [2];

  as_slave_bpi #(.wait_cycles(1)) u_w1 (
    .clk_i(clk), .rst_i(rst[0]), .wb_s_addr_i(addr[0]), .wb_s_dat_i(wdat[0]),
    .wb_s_dat_o(rdat[0]), .wb_s_we_i(we[0]), .wb_s_sel_i(sel[0]), .wb_s_stb_i(stb[0]),
    .wb_s_cyc_i(cyc[0]), .wb_s_ack_o(ack[0]), .ctrl_o(ctrl[0]), .data_o(data[0]),
    .status_i(status[0])
  );

  as_slave_bpi #(.wait_cycles(3)) u_w3 (
    .clk_i(clk), .rst_i(rst[1]), .wb_s_addr_i(addr[1]), .wb_s_dat_i(wdat[1]),
    .wb_s_dat_o(rdat[1]), .wb_s_we_i(we[1]), .wb_s_sel_i(sel[1]), .wb_s_stb_i(stb[1]),
    .wb_s_cyc_i(cyc[1]), .wb_s_ack_o(ack[1]), .ctrl_o(ctrl[1]), .data_o(data[1]),
    .status_i(status[1])
  );

  // Register-level model of each instance.
  logic [63:0] m_ctrl [2];
  logic [63:0] m_data [2];
  logic [63:0] m_dat  [2];
  logic        m_ack  [2];
  bit          chk_en = 1'b0;
  int          tests  = 0;
  int          fails  = 0;

  function automatic int wait_of(int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic logic [63:0] merge(logic [63:0] old, logic [63:0] d, logic [7:0] s);
    logic [63:0] r;
    r = old;
    for (int k = 0; k < 8; k++) if (s[k]) r[8*k +: 8] = d[8*k +: 8];
    return r;
  endfunction

  function automatic logic [63:0] read_model(int i, logic [63:0] a);
    logic [1:0] idx;
    idx = a[4:3];
    case (idx)
      2'd0:    return ID_VAL;
      2'd1:    return m_ctrl[i];
      2'd2:    return m_data[i];
      default: return status[i];
    endcase
  endfunction

  task automatic model_reset(int i);
    m_ctrl[i] = '0;
    m_data[i] = '0;
    m_dat[i]  = '0;
    m_ack[i]  = 1'b0;
  endtask

  task automatic check(string name, int i, logic [63:0] got, logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s inst%0d t=%0t got=%h exp=%h", name, i, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        check("ack",    i, 64'(ack[i]), 64'(m_ack[i]));
        check("dat_o",  i, rdat[i], m_dat[i]);
        check("ctrl_o", i, ctrl[i], m_ctrl[i]);
        check("data_o", i, data[i], m_data[i]);
      end
    end
  end

  // One bus transfer. abort_k > 0 drops cyc in that WAIT cycle; keep leaves the
  // request asserted through ACK so the next call issues a back-to-back request.
  task automatic xfer(int i, bit w, logic [63:0] a, logic [63:0] d, logic [7:0] s,
                      int abort_k, bit keep);
    @(posedge clk);
    m_ack[i] = 1'b0;
    #1;
    cyc[i] = 1'b1; stb[i] = 1'b1; we[i] = w; addr[i] = a; wdat[i] = d; sel[i] = s;
    for (int c = 1; c <= wait_of(i) + 1; c++) begin
      @(posedge clk);
      if (c == wait_of(i) + 1) begin
        m_ack[i] = 1'b1;
        if (w) begin
          if (a[4:3] == 2'd1) m_ctrl[i] = merge(m_ctrl[i], d, s);
          if (a[4:3] == 2'd2) m_data[i] = merge(m_data[i], d, s);
        end else begin
          m_dat[i] = read_model(i, a);
        end
      end
      #1;
      if (c <= wait_of(i)) begin
        // Bus contents must not matter after capture, and stb may drop.
        stb[i] = 1'b0; addr[i] = a ^ 64'h18; wdat[i] = ~d; sel[i] = ~s; we[i] = ~w;
        if (c == abort_k) begin
          cyc[i] = 1'b0;
          @(posedge clk);
          return;
        end
      end else if (keep) begin
        cyc[i] = 1'b1; stb[i] = 1'b1;
      end else begin
        cyc[i] = 1'b0; stb[i] = 1'b0;
      end
    end
    if (!keep) begin
      @(posedge clk);
      m_ack[i] = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; addr[i] = '0; wdat[i] = '0; we[i] = 1'b0; stb[i] = 1'b0;
      cyc[i] = 1'b0; sel[i] = '0; model_reset(i);
    end
    status[0] = 64'h5A;
    status[1] = 64'h0000_1234_5678_9ABC;
    @(posedge clk);
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    rst[0] = 1'b0; rst[1] = 1'b0;
    check("rst_dat", 0, rdat[0], 64'h0);
    check("rst_ack", 1, 64'(ack[1]), 64'h0);

    // ID read, then full CTRL write/readback
    xfer(0, 1'b0, 64'h00, 64'h0, 8'hFF, 0, 1'b0);
    check("id_read", 0, rdat[0], 64'hC0FFEE00C0FFEE00);
    xfer(0, 1'b1, 64'h08, 64'h1122334455667788, 8'hFF, 0, 1'b0);
    xfer(0, 1'b0, 64'h08, 64'h0, 8'h00, 0, 1'b0);
    check("ctrl_o", 0, ctrl[0], 64'h1122334455667788);
    check("ctrl_rd", 0, rdat[0], 64'h1122334455667788);

    // Byte-enabled DATA writes
    xfer(0, 1'b1, 64'h10, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 0, 1'b0);
    check("data_lo", 0, data[0], 64'h00000000AAAAAAAA);
    xfer(0, 1'b1, 64'h10, 64'h5555555555555555, 8'hC0, 0, 1'b0);
    check("data_hi", 0, data[0], 64'h55550000AAAAAAAA);

    // Writes to read-only registers are acked and ignored
    xfer(0, 1'b1, 64'h00, 64'h0, 8'hFF, 0, 1'b0);
    xfer(0, 1'b1, 64'h18, 64'h0, 8'hFF, 0, 1'b0);
    xfer(0, 1'b0, 64'h00, 64'h0, 8'hFF, 0, 1'b0);
    check("id_kept", 0, rdat[0], 64'hC0FFEE00C0FFEE00);
    xfer(0, 1'b0, 64'h18, 64'h0, 8'hFF, 0, 1'b0);
    check("status", 0, rdat[0], 64'h5A);

    // Upper address bits ignored; then back-to-back reads
    xfer(0, 1'b0, 64'hFFFF_0000_0000_0028, 64'h0, 8'h00, 0, 1'b0);
    check("alias", 0, rdat[0], 64'h1122334455667788);
    xfer(0, 1'b0, 64'h08, 64'h0, 8'h00, 0, 1'b1);
    xfer(0, 1'b0, 64'h10, 64'h0, 8'h00, 0, 1'b0);
    check("b2b", 0, rdat[0], 64'h55550000AAAAAAAA);

    // Three wait states: commit, aborted write, read after abort
    xfer(1, 1'b1, 64'h08, 64'h0123456789ABCDEF, 8'hFF, 0, 1'b0);
    xfer(1, 1'b1, 64'h08, 64'hDEADBEEFDEADBEEF, 8'hFF, 2, 1'b0);
    check("abort_ctrl", 1, ctrl[1], 64'h0123456789ABCDEF);
    xfer(1, 1'b0, 64'h08, 64'h0, 8'h00, 0, 1'b0);
    check("post_abort", 1, rdat[1], 64'h0123456789ABCDEF);
    xfer(1, 1'b1, 64'h10, 64'hFFEEDDCCBBAA9988, 8'h81, 0, 1'b0);
    check("data_81", 1, data[1], 64'hFF00000000000088);
    xfer(1, 1'b0, 64'h18, 64'h0, 8'h00, 0, 1'b0);
    check("status3", 1, rdat[1], 64'h0000_1234_5678_9ABC);

    // Reset in the WAIT cycle of a DATA write, request held afterwards
    @(posedge clk);
    #1;
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; addr[0] = 64'h10;
    wdat[0] = 64'h0000_0000_0000_FEED; sel[0] = 8'hFF;
    @(posedge clk);
    #1;
    rst[0] = 1'b1;
    @(posedge clk);
    model_reset(0);
    #1;
    rst[0] = 1'b0;
    check("rst_data", 0, data[0], 64'h0);
    check("rst_noack", 0, 64'(ack[0]), 64'h0);
    @(posedge clk);
    @(posedge clk);
    m_ack[0]  = 1'b1;
    m_data[0] = 64'h0000_0000_0000_FEED;
    #1;
    cyc[0] = 1'b0; stb[0] = 1'b0;
    check("rst_reack", 0, 64'(ack[0]), 64'h1);
    @(posedge clk);
    m_ack[0] = 1'b0;
    #1;
    check("rst_wr", 0, data[0], 64'h0000_0000_0000_FEED);

    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
